hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: memory-wait cycles before MemTimeout sets.
REQ-002 SHALL have parameter CNT_W, default 32: width of StallCount.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports Rs1D, Rs2D  input  5  source registers of the instruction in D.
REQ-006 SHALL have ports Rs1E, Rs2E, RdE  input  5  source and destination registers of the instruction in E.
REQ-007 SHALL have ports RdM, RdW  input  5  destination registers of the instructions in M and W.
REQ-008 SHALL have ports RegWriteM, RegWriteW  input  1  register-write enables of the instructions in M and W.
REQ-009 SHALL have port ResultSrcE  input  2  result select in E; 2'b01 marks a load.
REQ-010 SHALL have port PCSrcE  input  1  taken branch or jump resolved in E.
REQ-011 SHALL have port MemReqM  input  1  data-memory access pending in M.
REQ-012 SHALL have port MemReadyM  input  1  data memory completes the M access this cycle.
REQ-013 SHALL have ports ForwardAE, ForwardBE  output  2  operand-bypass selects (00 regfile, 01 W result, 10 M ALU result).
REQ-014 SHALL have ports StallF, StallD, StallE, StallM  output  1  hold the F, D, E and M pipeline registers.
REQ-015 SHALL have ports FlushD, FlushE, FlushW  output  1  load a bubble into D, E and W.
REQ-016 SHALL have port StallCount  output  CNT_W  stall-cycle performance counter.
REQ-017 SHALL have port MemTimeout  output  1  sticky memory-timeout error flag.

Function
REQ-018 ForwardAE SHALL be 10 if RegWriteM & RdM!=0 & RdM==Rs1E, else 01 if RegWriteW & RdW!=0 & RdW==Rs1E, else 00; the M match takes priority over W. ForwardBE SHALL be identical, using Rs2E.
REQ-019 memWait = MemReqM & !MemReadyM; while memWait=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0, regardless of any other condition.
REQ-020 lwStall = ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-021 When memWait=0 and PCSrcE=1: FlushD=FlushE=1, all stalls 0; PCSrcE SHALL suppress lwStall.
REQ-022 When memWait=0, PCSrcE=0 and lwStall=1: StallF=StallD=1, FlushE=1, all other stall and flush outputs 0.
REQ-023 Stall, flush and forward outputs SHALL be combinational, with zero-cycle latency from their inputs.
REQ-024 The FSM SHALL have two states, RUN and MEM_WAIT: RUN->MEM_WAIT on memWait; MEM_WAIT->RUN on MemReadyM or !MemReqM; any other case holds the current state.
REQ-025 An internal 8-bit WaitCnt SHALL clear in RUN and increment each cycle in MEM_WAIT while memWait=1, saturating at 255.
REQ-026 MemTimeout SHALL set on the edge where WaitCnt==WAIT_LIMIT-1 and memWait=1, and SHALL clear only on reset.
REQ-027 StallCount SHALL increment on each edge where any Stall* output is 1, and SHALL saturate at all-ones with no wrap-around.
REQ-028 A cycle with MemReadyM=1 SHALL produce no stall; the access completes and the pipeline advances that edge.

Reset
REQ-029 While reset=1: state=RUN, WaitCnt=0, StallCount=0, MemTimeout=0, all Stall* outputs=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00.
REQ-030 Reset asserted during MEM_WAIT SHALL abandon the wait immediately, with no counter update on that edge.

Structure
REQ-031 A shared package SHALL hold: the ResultSrc load encoding (2'b01), the forward-select encodings, the FSM state enum, and the WAIT_LIMIT default.
REQ-032 Forwarding logic SHALL live in one sub-module, forward_sel, instantiated once for operand A and once for operand B.

Verification
REQ-033 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; with RdM=0 -> ForwardAE=01.
REQ-034 ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for 1 cycle; StallCount +1.
REQ-035 Same as REQ-034 but PCSrcE=1 -> FlushD=FlushE=1, StallF=0.
REQ-036 MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> 4-stall-output hold and FlushW=1 for 3 cycles; state returns to RUN; StallCount=3.
REQ-037 MemReqM=1, MemReadyM=0 for 300 cycles -> MemTimeout=1 from edge 255 onward; it persists after MemReadyM=1; clears only on reset.
REQ-038 Reset pulse in MEM_WAIT with WaitCnt=10 -> all REQ-029 values hold asynchronously; after reset release, state=RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the load encoding of ResultSrc, the operand-bypass select codes,
// the controller FSM state type, the default memory-wait limit and a
// saturating increment helper used by the wait counter.
package hazard_ctrl_pkg;

  // ResultSrc value that marks the instruction in E as a load.
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Operand-bypass select encodings.
  localparam logic [1:0] FWD_REGFILE  = 2'b00;
  localparam logic [1:0] FWD_W_RESULT = 2'b01;
  localparam logic [1:0] FWD_M_ALU    = 2'b10;

  // Default number of memory-wait cycles before the timeout flag sets.
  localparam int WAIT_LIMIT_DEFAULT = 255;

  // Controller FSM states.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // 8-bit increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/forward_sel.sv
// Operand-bypass selector for one source operand of the instruction in E.
// Ports:
//   rs_e                     source register of the operand in E
//   rd_m, reg_write_m        destination / write enable of the M instruction
//   rd_w, reg_write_w        destination / write enable of the W instruction
//   fwd                      bypass select (regfile, W result, M ALU result)
// The younger M result wins over W; x0 is never bypassed.
module forward_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // Priority bypass select: M before W before register file.
  always_comb begin
    fwd = FWD_REGFILE;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd = FWD_M_ALU;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_W_RESULT;
    end else begin
      fwd = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand bypass selects, stall/flush control
// for load-use, control and memory-wait hazards, a memory-wait FSM with a
// sticky timeout flag, and a saturating stall-cycle counter.
// Ports:
//   CLK, reset                          clock, async active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW   register specifiers per stage
//   RegWriteM/W, ResultSrcE, PCSrcE     write enables, E result select, redirect
//   MemReqM, MemReadyM                  data-memory handshake in M
//   ForwardAE/BE                        bypass selects (combinational)
//   StallF/D/E/M, FlushD/E/W            pipeline control (combinational)
//   StallCount, MemTimeout              registered status
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeout
);

  // WaitCnt value on whose cycle a still-pending access trips the timeout.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e        state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic             mem_wait, lw_stall, stall_any;
  logic [1:0]       fwd_a, fwd_b;

  forward_sel u_fwd_a (
    .rs_e        (Rs1E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs_e        (Rs2E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  // Hazard detection and stall/flush/forward outputs.
  // Priority: reset, memory wait, taken redirect (kills the load-use stall
  // since the dependent instruction is squashed anyway), load-use.
  always_comb begin
    mem_wait  = MemReqM & ~MemReadyM;
    lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    if (reset) begin
      ForwardAE = FWD_REGFILE;
      ForwardBE = FWD_REGFILE;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end else if (mem_wait) begin
      // Freeze F..M; W gets a bubble since the M result is not ready.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      FlushW = 1'b0;
    end
  end

  // FSM next state, wait counter, timeout and stall-counter next values.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // Leaving MEM_WAIT clears the count so RUN always starts from zero.
        if (mem_wait) begin
          wait_cnt_d = sat_inc8(wait_cnt_q);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    mem_timeout_d = mem_timeout_q | (mem_wait && (wait_cnt_q == WAIT_LAST));

    stall_any = StallF | StallD | StallE | StallM;
    if (stall_any && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State and status registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      stall_count_q <= {CNT_W{1'b0}};
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_count_q <= stall_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign StallCount = stall_count_q;
  assign MemTimeout = mem_timeout_q;

endmodule
